// File: rtl/crypto_pkg.sv
// crypto_pkg: shared sequencer state encoding, engine ids and defaults for
// the crypto job sequencer (accel_sched) and its watchdog.
package crypto_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3,
        DROP   = 3'd4
    } state_t;

    typedef logic [1:0] eng_t;

    localparam eng_t ENG_H    = 2'd0;
    localparam eng_t ENG_E    = 2'd1;
    localparam eng_t ENG_D    = 2'd2;
    localparam eng_t ENG_NONE = 2'd3;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Fixed priority H > E > D among simultaneously raised requests.
    function automatic eng_t pick_engine(input logic h, input logic e, input logic d);
        if (h) return ENG_H;
        if (e) return ENG_E;
        if (d) return ENG_D;
        return ENG_NONE;
    endfunction

    // One-hot engine vector, bit 2 = H, bit 1 = E, bit 0 = D.
    function automatic logic [2:0] eng_onehot(input eng_t eng);
        case (eng)
            ENG_H:   return 3'b100;
            ENG_E:   return 3'b010;
            ENG_D:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/accel_watchdog.sv
// accel_watchdog: RUN-state cycle counter with saturation and the watchdog
// expiry compare. Only instantiated when ACCEL_TIMEOUT_EN is defined.
module accel_watchdog
    import crypto_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    // count = RUN cycles spent including the current one, saturating at all-ones.
    assign count   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign expired = run && (count == LIMIT);

    // Counter register: cleared on launch, advanced once per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= count;
        end
    end

endmodule

// File: rtl/accel_sched.sv
// accel_sched: one-job-at-a-time sequencer between decode-stage requests and
// the hash/encrypt/decrypt engines. Optional watchdog under ACCEL_TIMEOUT_EN.
module accel_sched
    import crypto_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              H_int,
    input  logic              E_int,
    input  logic              D_int,
    input  logic [ADDR_W-1:0] index,
    input  logic              h_fin,
    input  logic              e_fin,
    input  logic              d_fin,
    output logic              H_done,
    output logic              E_done,
    output logic              D_done,
    output logic              h_start,
    output logic              e_start,
    output logic              d_start,
    output logic [ADDR_W-1:0] eng_base,
    output logic [2:0]        buf_gnt,
    output logic              busy,
    output logic              err,
    output logic              abort,
    output logic [CNT_W-1:0]  last_cycles
);

    // Handshake: a request is a level held by the CPU; it is accepted in IDLE,
    // answered by exactly one *_done pulse, and must be dropped before the
    // sequencer returns to IDLE and can accept the next request.

    state_t           state, state_nx;
    eng_t             eng;
    logic [2:0]       eng_oh;
    logic             any_req, req_sel, fin_sel, run, expired;
    logic [CNT_W-1:0] run_count;

    assign any_req = H_int | E_int | D_int;
    assign run     = (state == RUN);
    assign eng_oh  = eng_onehot(eng);
    assign req_sel = |(eng_oh & {H_int, E_int, D_int});
    assign fin_sel = |(eng_oh & {h_fin, e_fin, d_fin});

`ifdef ACCEL_TIMEOUT_EN
    accel_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == LAUNCH),
        .run     (run),
        .count   (run_count),
        .expired (expired)
    );
`else
    logic [CNT_W-1:0] cnt_q;

    assign run_count = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign expired   = 1'b0;

    // Local RUN cycle counter: cleared on launch, saturating increment in RUN.
    always_ff @(posedge clk) begin
        if (rst || state == LAUNCH) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= run_count;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; only the latched engine's fin and request matter.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = LAUNCH;
            LAUNCH:  state_nx = RUN;
            RUN:     if (fin_sel || expired) state_nx = DONE;
            DONE:    state_nx = DROP;
            DROP:    if (!req_sel) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Job context: engine id and base latched on acceptance, cycle count on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng         <= ENG_NONE;
            eng_base    <= '0;
            last_cycles <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                eng      <= pick_engine(H_int, E_int, D_int);
                eng_base <= index;
            end
            if (run && (fin_sel || expired)) begin
                last_cycles <= run_count;
            end
        end
    end

`ifdef ACCEL_TIMEOUT_EN
    logic err_q, timed_out;

    // Watchdog status: timed_out marks the current job, err is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                timed_out <= 1'b0;
            end else if (run && expired && !fin_sel) begin
                timed_out <= 1'b1;
                err_q     <= 1'b1;
            end
        end
    end

    assign err   = err_q;
    assign abort = (state == DONE) && timed_out;
`else
    assign err   = 1'b0;
    assign abort = 1'b0;
`endif

    assign {h_start, e_start, d_start} = (state == LAUNCH) ? eng_oh : 3'b000;
    assign buf_gnt                     = (state == LAUNCH || state == RUN) ? eng_oh : 3'b000;
    assign {H_done, E_done, D_done}    = (state == DONE) ? eng_oh : 3'b000;
    assign busy                        = (state != IDLE);

endmodule

// File: tb/tb_accel_sched.sv
// tb_accel_sched: directed and random job scenarios for accel_sched with a
// done-pulse scoreboard. Watchdog scenarios run when ACCEL_TIMEOUT_EN is defined.
module tb_accel_sched;

    localparam int ADDR_W  = 11;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;
    localparam int SB_W    = 5 + ADDR_W + CNT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              H_int = 1'b0, E_int = 1'b0, D_int = 1'b0;
    logic [ADDR_W-1:0] index = '0;
    logic              h_fin = 1'b0, e_fin = 1'b0, d_fin = 1'b0;
    logic              H_done, E_done, D_done;
    logic              h_start, e_start, d_start;
    logic [ADDR_W-1:0] eng_base;
    logic [2:0]        buf_gnt;
    logic              busy, err, abort;
    logic [CNT_W-1:0]  last_cycles;

    logic [SB_W-1:0]   exp_q[$];
    int                vectors     = 0;
    int                miscompares = 0;

    accel_sched #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .H_int       (H_int),
        .E_int       (E_int),
        .D_int       (D_int),
        .index       (index),
        .h_fin       (h_fin),
        .e_fin       (e_fin),
        .d_fin       (d_fin),
        .H_done      (H_done),
        .E_done      (E_done),
        .D_done      (D_done),
        .h_start     (h_start),
        .e_start     (e_start),
        .d_start     (d_start),
        .eng_base    (eng_base),
        .buf_gnt     (buf_gnt),
        .busy        (busy),
        .err         (err),
        .abort       (abort),
        .last_cycles (last_cycles)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: run still active at 100000ns, expected summary earlier");
        $fatal(1, "bench time limit reached");
    end

    // ---------------- helpers ----------------
    function automatic logic [2:0] oh(input int e);
        logic [2:0] v;
        v = 3'b100;
        return v >> e;
    endfunction

    function automatic logic [SB_W-1:0] mk_exp(input logic [2:0] dn, input logic e_b,
                                               input logic a_b, input logic [ADDR_W-1:0] base,
                                               input logic [CNT_W-1:0] last);
        return {dn, e_b, a_b, base, last};
    endfunction

    task automatic set_req(input int e, input logic v);
        case (e)
            0:       H_int = v;
            1:       E_int = v;
            default: D_int = v;
        endcase
    endtask

    task automatic clear_fins();
        h_fin = 1'b0;
        e_fin = 1'b0;
        d_fin = 1'b0;
    endtask

    task automatic set_fin(input int e);
        case (e)
            0:       h_fin = 1'b1;
            1:       e_fin = 1'b1;
            default: d_fin = 1'b1;
        endcase
    endtask

    // Sample at the falling edge; any done pulse is checked against the scoreboard.
    task automatic sample();
        logic [SB_W-1:0] obs, e;
        @(negedge clk);
        if (!rst && (H_done || E_done || D_done)) begin
            obs = {H_done, E_done, D_done, err, abort, eng_base, last_cycles};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_done: got %h, expected no done pulse", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL sb_done: got %h, expected %h", obs, e);
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) advance();
        sample();
        vectors++;
        if ({H_done, E_done, D_done, h_start, e_start, d_start, eng_base, buf_gnt,
             busy, err, abort, last_cycles} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got nonzero outputs busy=%b gnt=%b base=%h, expected all 0",
                     busy, buf_gnt, eng_base);
        end
        advance();
        rst = 1'b0;
        sample();
        vectors++;
        if (busy !== 1'b0 || buf_gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release_idle: got busy=%b gnt=%b, expected 0/000", busy, buf_gnt);
        end
        advance();
    endtask

    task automatic test_basic_e();
        index = 11'h040;
        E_int = 1'b1;
        exp_q.push_back(mk_exp(3'b010, 1'b0, 1'b0, 11'h040, 16'd5));
        for (int c = 0; c <= 9; c++) begin
            clear_fins();
            if (c == 1) index = 11'h7FF;
            if (c == 6) e_fin = 1'b1;
            if (c == 8) E_int = 1'b0;
            sample();
            vectors++;
            if ({h_start, e_start, d_start} !== ((c == 1) ? 3'b010 : 3'b000)) begin
                miscompares++;
                $display("FAIL basic_start c%0d: got %b, expected %b", c,
                         {h_start, e_start, d_start}, (c == 1) ? 3'b010 : 3'b000);
            end
            vectors++;
            if (buf_gnt !== ((c >= 1 && c <= 6) ? 3'b010 : 3'b000)) begin
                miscompares++;
                $display("FAIL basic_gnt c%0d: got %b, expected %b", c, buf_gnt,
                         (c >= 1 && c <= 6) ? 3'b010 : 3'b000);
            end
            vectors++;
            if (E_done !== (c == 7)) begin
                miscompares++;
                $display("FAIL basic_done c%0d: got %b, expected %b", c, E_done, (c == 7));
            end
            vectors++;
            if (busy !== (c >= 1 && c <= 8)) begin
                miscompares++;
                $display("FAIL basic_busy c%0d: got %b, expected %b", c, busy, (c >= 1 && c <= 8));
            end
            if (c == 9) begin
                vectors++;
                if (eng_base !== 11'h040 || last_cycles !== 16'd5) begin
                    miscompares++;
                    $display("FAIL basic_hold: got base=%h last=%0d, expected base=040 last=5",
                             eng_base, last_cycles);
                end
            end
            advance();
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_st, exp_gnt, exp_dn;
        index = 11'h100;
        H_int = 1'b1;
        D_int = 1'b1;
        exp_q.push_back(mk_exp(3'b100, 1'b0, 1'b0, 11'h100, 16'd2));
        exp_q.push_back(mk_exp(3'b001, 1'b0, 1'b0, 11'h155, 16'd1));
        for (int c = 0; c <= 11; c++) begin
            clear_fins();
            if (c == 3) h_fin = 1'b1;
            if (c == 5) begin H_int = 1'b0; index = 11'h155; end
            if (c == 8) d_fin = 1'b1;
            if (c == 10) D_int = 1'b0;
            sample();
            exp_st  = (c == 1) ? 3'b100 : (c == 7) ? 3'b001 : 3'b000;
            exp_gnt = (c >= 1 && c <= 3) ? 3'b100 : (c >= 7 && c <= 8) ? 3'b001 : 3'b000;
            exp_dn  = (c == 4) ? 3'b100 : (c == 9) ? 3'b001 : 3'b000;
            vectors++;
            if ({h_start, e_start, d_start} !== exp_st) begin
                miscompares++;
                $display("FAIL prio_start c%0d: got %b, expected %b", c, {h_start, e_start, d_start}, exp_st);
            end
            vectors++;
            if (buf_gnt !== exp_gnt) begin
                miscompares++;
                $display("FAIL prio_gnt c%0d: got %b, expected %b", c, buf_gnt, exp_gnt);
            end
            vectors++;
            if ({H_done, E_done, D_done} !== exp_dn) begin
                miscompares++;
                $display("FAIL prio_done c%0d: got %b, expected %b", c, {H_done, E_done, D_done}, exp_dn);
            end
            vectors++;
            if (busy !== ((c >= 1 && c <= 5) || (c >= 7 && c <= 10))) begin
                miscompares++;
                $display("FAIL prio_busy c%0d: got %b, expected %b", c, busy,
                         ((c >= 1 && c <= 5) || (c >= 7 && c <= 10)));
            end
            advance();
        end
    endtask

    task automatic test_ignore_other();
        logic [2:0] exp_st, exp_dn;
        index = 11'h2AA;
        H_int = 1'b1;
        exp_q.push_back(mk_exp(3'b100, 1'b0, 1'b0, 11'h2AA, 16'd5));
        exp_q.push_back(mk_exp(3'b010, 1'b0, 1'b0, 11'h0F0, 16'd1));
        for (int c = 0; c <= 14; c++) begin
            clear_fins();
            if (c == 1) h_fin = 1'b1;
            if (c == 3) begin E_int = 1'b1; index = 11'h0F0; end
            if (c == 4) begin e_fin = 1'b1; d_fin = 1'b1; end
            if (c == 6) h_fin = 1'b1;
            if (c == 8) H_int = 1'b0;
            if (c == 11) e_fin = 1'b1;
            if (c == 13) E_int = 1'b0;
            sample();
            exp_st = (c == 1) ? 3'b100 : (c == 10) ? 3'b010 : 3'b000;
            exp_dn = (c == 7) ? 3'b100 : (c == 12) ? 3'b010 : 3'b000;
            vectors++;
            if ({h_start, e_start, d_start} !== exp_st) begin
                miscompares++;
                $display("FAIL ignore_start c%0d: got %b, expected %b", c, {h_start, e_start, d_start}, exp_st);
            end
            vectors++;
            if ({H_done, E_done, D_done} !== exp_dn) begin
                miscompares++;
                $display("FAIL ignore_done c%0d: got %b, expected %b", c, {H_done, E_done, D_done}, exp_dn);
            end
            if (c >= 2 && c <= 6) begin
                vectors++;
                if (buf_gnt !== 3'b100 || eng_base !== 11'h2AA) begin
                    miscompares++;
                    $display("FAIL ignore_hold c%0d: got gnt=%b base=%h, expected 100/2aa", c, buf_gnt, eng_base);
                end
            end
            advance();
        end
    endtask

`ifdef ACCEL_TIMEOUT_EN
    task automatic test_fin_at_expiry();
        index = 11'h0AB;
        E_int = 1'b1;
        exp_q.push_back(mk_exp(3'b010, 1'b0, 1'b0, 11'h0AB, CNT_W'(TIMEOUT)));
        for (int c = 0; c <= 12; c++) begin
            clear_fins();
            if (c == 9) e_fin = 1'b1;
            if (c == 11) E_int = 1'b0;
            sample();
            vectors++;
            if (abort !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL race_status c%0d: got abort=%b err=%b, expected 0/0", c, abort, err);
            end
            vectors++;
            if (E_done !== (c == 10)) begin
                miscompares++;
                $display("FAIL race_done c%0d: got %b, expected %b", c, E_done, (c == 10));
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        index = 11'h001;
        D_int = 1'b1;
        exp_q.push_back(mk_exp(3'b001, 1'b1, 1'b1, 11'h001, CNT_W'(TIMEOUT)));
        for (int c = 0; c <= 12; c++) begin
            clear_fins();
            if (c == 11) D_int = 1'b0;
            sample();
            vectors++;
            if (abort !== (c == 10) || D_done !== (c == 10)) begin
                miscompares++;
                $display("FAIL wd_pulse c%0d: got abort=%b done=%b, expected %b", c, abort, D_done, (c == 10));
            end
            vectors++;
            if (err !== (c >= 10)) begin
                miscompares++;
                $display("FAIL wd_err c%0d: got %b, expected %b", c, err, (c >= 10));
            end
            vectors++;
            if (buf_gnt !== ((c >= 1 && c <= 9) ? 3'b001 : 3'b000)) begin
                miscompares++;
                $display("FAIL wd_gnt c%0d: got %b, expected %b", c, buf_gnt,
                         (c >= 1 && c <= 9) ? 3'b001 : 3'b000);
            end
            advance();
        end
    endtask
`else
    task automatic test_no_timeout();
        index = 11'h321;
        D_int = 1'b1;
        exp_q.push_back(mk_exp(3'b001, 1'b0, 1'b0, 11'h321, 16'd30));
        for (int c = 0; c <= 34; c++) begin
            clear_fins();
            if (c == 31) d_fin = 1'b1;
            if (c == 33) D_int = 1'b0;
            sample();
            vectors++;
            if (abort !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL nowd_status c%0d: got abort=%b err=%b, expected 0/0", c, abort, err);
            end
            vectors++;
            if (D_done !== (c == 32) || busy !== (c >= 1 && c <= 33)) begin
                miscompares++;
                $display("FAIL nowd_seq c%0d: got done=%b busy=%b, expected %b/%b", c, D_done, busy,
                         (c == 32), (c >= 1 && c <= 33));
            end
            advance();
        end
    endtask
`endif

    task automatic test_reset_mid();
        index = 11'h3C3;
        D_int = 1'b1;
        exp_q.push_back(mk_exp(3'b001, 1'b0, 1'b0, 11'h3C3, 16'd2));
        for (int c = 0; c <= 11; c++) begin
            clear_fins();
            rst = (c == 4);
            if (c == 8) d_fin = 1'b1;
            if (c == 10) D_int = 1'b0;
            sample();
            if (c == 5) begin
                vectors++;
                if ({H_done, E_done, D_done, h_start, e_start, d_start, eng_base, buf_gnt,
                     busy, err, abort, last_cycles} !== '0) begin
                    miscompares++;
                    $display("FAIL midrst_outputs: got busy=%b gnt=%b base=%h err=%b last=%0d, expected all 0",
                             busy, buf_gnt, eng_base, err, last_cycles);
                end
            end
            vectors++;
            if (d_start !== (c == 1 || c == 6) || abort !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_start c%0d: got start=%b abort=%b, expected %b/0", c, d_start, abort,
                         (c == 1 || c == 6));
            end
            if (c == 6) begin
                vectors++;
                if (eng_base !== 11'h3C3) begin
                    miscompares++;
                    $display("FAIL midrst_base: got %h, expected 3c3", eng_base);
                end
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int                e, d, f;
        logic [ADDR_W-1:0] idx;
        for (int j = 0; j < 6; j++) begin
            e   = $urandom_range(0, 2);
            d   = $urandom_range(0, 5);
            f   = 2 + d;
            idx = ADDR_W'($urandom_range(0, 2047));
            exp_q.push_back(mk_exp(oh(e), 1'b0, 1'b0, idx, CNT_W'(d + 1)));
            for (int c = 0; c <= f + 2; c++) begin
                clear_fins();
                if (c == 0) begin
                    index = idx;
                    set_req(e, 1'b1);
                end else begin
                    index = ADDR_W'($urandom_range(0, 2047));
                end
                if (c == f) set_fin(e);
                if (c == f + 2) set_req(e, 1'b0);
                sample();
                if (c == 0) begin
                    vectors++;
                    if (busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL b2b_idle job%0d: got busy=%b, expected 0", j, busy);
                    end
                end
                vectors++;
                if ({h_start, e_start, d_start} !== ((c == 1) ? oh(e) : 3'b000)) begin
                    miscompares++;
                    $display("FAIL b2b_start job%0d c%0d: got %b, expected %b", j, c,
                             {h_start, e_start, d_start}, (c == 1) ? oh(e) : 3'b000);
                end
                vectors++;
                if ({H_done, E_done, D_done} !== ((c == f + 1) ? oh(e) : 3'b000)) begin
                    miscompares++;
                    $display("FAIL b2b_done job%0d c%0d: got %b, expected %b", j, c,
                             {H_done, E_done, D_done}, (c == f + 1) ? oh(e) : 3'b000);
                end
                advance();
            end
        end
        clear_fins();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_e();
        test_priority();
        test_ignore_other();
`ifdef ACCEL_TIMEOUT_EN
        test_fin_at_expiry();
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        test_back_to_back();
        repeat (3) begin
            sample();
            advance();
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending done pulses, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/accel_sched.md
# accel_sched

Job sequencer between the pipelined CPU's decode-stage side-channel requests (`H_int`, `E_int`, `D_int`) and the three crypto engines: hash, encrypt and decrypt. It runs one job at a time:
- accepts a held request and latches the operand base `index`;
- launches the selected engine and grants it the shared operand buffer;
- waits for the engine to finish (or for the watchdog to expire), then returns a one-cycle done pulse that releases the CPU stall.

## Interface
Parameters:
- `ADDR_W`, 11, width of operand base address (matches CPU `index`)
- `TIMEOUT`, 1024, watchdog limit in cycles spent in RUN
- `CNT_W`, 16, width of job cycle counter

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `H_int`, `E_int`, `D_int`  in  1 each  level requests from decode; held until the matching done pulse
- `index`  in  ADDR_W  operand base address, valid while any request is high
- `h_fin`, `e_fin`, `d_fin`  in  1 each  engine completion, single-cycle pulse
- `H_done`, `E_done`, `D_done`  out  1 each  completion pulse to CPU
- `h_start`, `e_start`, `d_start`  out  1 each  engine launch pulse
- `eng_base`  out  ADDR_W  latched base address for the active engine
- `buf_gnt`  out  3  one-hot shared-buffer grant, bit 2 = H, bit 1 = E, bit 0 = D
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  sticky; set on watchdog expiry
- `abort`  out  1  one-cycle pulse to the active engine on watchdog expiry
- `last_cycles`  out  CNT_W  RUN-state cycle count of the most recently completed job

Reset values: every output is 0.

## Operation
State machine states: IDLE, LAUNCH, RUN, DONE, DROP.
- IDLE
  - If any request is high: latch `index` into `eng_base` and the engine id, then go to LAUNCH.
  - Priority when several requests are high: H > E > D.
- LAUNCH (1 cycle)
  - Assert the start pulse of the latched engine.
  - Drive `buf_gnt` for the latched engine.
  - Clear the cycle counter; go to RUN.
- RUN
  - `buf_gnt` is held; the counter increments each cycle, saturating at all-ones.
  - Only the latched engine's `*_fin` is honoured; other `fin` inputs are ignored.
  - On fin: copy the counter to `last_cycles`, go to DONE.
- DONE (1 cycle)
  - Pulse the matching `*_Done`; `buf_gnt` = 0.
  - Go to DROP.
- DROP
  - Wait until the latched engine's request is low, then go to IDLE.
  - This prevents relaunching on a request the CPU has not yet dropped.

Boundary rules:
- A fin arriving during LAUNCH (same cycle as start) is ignored.
- Request changes during LAUNCH or RUN (new engine raised, latched one dropped) are ignored; the job completes and done is still pulsed.
- `index` changes after latching do not affect `eng_base`.
- `rst` mid-job: immediate return to IDLE, all outputs 0, `err` cleared, no `abort` pulse.
- `eng_base` holds its value in IDLE (it is not cleared except by reset).

## Timing
- A request first high in cycle 0 is sampled at edge 1. The start pulse and `buf_gnt` are high in cycle 1. RUN begins in cycle 2.
- Engine fin in cycle k leads to the done pulse in cycle k+1, with `last_cycles` valid from cycle k+1.
- Minimum request-to-done latency: 3 cycles (fin in the first RUN cycle).
- Back-to-back jobs: a new request is sampled no earlier than the cycle after the request drop is seen in DROP.

## Configuration
- `ACCEL_TIMEOUT_EN` defined (watchdog compiled in):
  - When the RUN count reaches `TIMEOUT` with no fin, in the next cycle: pulse `abort`, set `err`, pulse the matching `*_Done`, set `last_cycles` = `TIMEOUT`, go to DROP.
  - If fin and timeout fall in the same cycle, fin wins: `err` is not set and no `abort` is pulsed.
- `ACCEL_TIMEOUT_EN` undefined: RUN waits indefinitely; `err` and `abort` are tied to 0; the `TIMEOUT` parameter is unused.

## Structure
- Shared package `crypto_pkg` contains:
  - state enum (IDLE, LAUNCH, RUN, DONE, DROP);
  - engine id encoding: `ENG_H`=2'd0, `ENG_E`=2'd1, `ENG_D`=2'd2, `ENG_NONE`=2'd3;
  - default `TIMEOUT` constant.
- One sub-module, `accel_watchdog`: the RUN cycle counter with saturation and the `expired` compare. It is instantiated only under `ACCEL_TIMEOUT_EN`; `last_cycles` is taken from its count, with a local counter used when the macro is undefined.

## Test plan
- E_int high with `index`=11'h040, e_fin 5 cycles after e_start:
  - e_start in cycle 1, `buf_gnt`=3'b010 in cycles 1–6, E_done in cycle 7, `eng_base`=11'h040, `last_cycles`=5.
- H_int and D_int raised together:
  - h_start only, `buf_gnt`=3'b100.
  - After H_done, hold D_int (H_int dropped): d_start occurs after DROP→IDLE.
- H job with E_int raised mid-RUN and e_fin pulsed during RUN:
  - e_fin is ignored; only H completes (H_done).
- `rst` asserted in RUN cycle 3:
  - next cycle all outputs are 0 and the state is IDLE; with the request still high, relaunch occurs.
- With `ACCEL_TIMEOUT_EN` and `TIMEOUT`=8, D job with no fin:
  - abort, `err`=1 and D_done in the same cycle; `last_cycles`=8.
- With `ACCEL_TIMEOUT_EN`, fin coinciding with expiry:
  - done pulses, `err`=0, no abort.
